// File: rtl/ir_pkg.sv
// Shared IR-remote definitions: entry FSM states and clock/digit constants.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    PEND
  } ir_entry_state_t;

  localparam int unsigned IR_DIGIT_MAX = 9;
  localparam int unsigned ir_clk_hz    = 50_000_000;

endpackage

// File: rtl/ir_idle_timer.sv
// Saturating inter-digit idle timer with a one-cycle expiry strobe.
module ir_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] PRE  = W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + W'(1);
    end
  end

  // Strobe on the step into LAST so the consumer changes state as the count lands there.
  assign expired = enable && !clear && ((TIMEOUT_CYCLES <= 1) || (count == PRE));

endmodule

// File: rtl/ir_number_entry.sv
// Collects IR remote digit strobes into multi-digit numbers and hands them to
// the CPU through a single-slot valid/ready register (BCD and binary).
module ir_number_entry
  import ir_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned BIN_W          = 14,
  parameter int unsigned TIMEOUT_CYCLES = ir_clk_hz
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  numberPressed,
  input  logic [3:0]            numberPressedData,
  input  logic                  err,
  input  logic                  outReady,
  output logic                  outValid,
  output logic [4*DIGITS-1:0]   outBcd,
  output logic [BIN_W-1:0]      outBin,
  output logic [3:0]            outCount,
  output logic                  entryActive,
  output logic                  dropped
);

  localparam int unsigned BCD_W = 4 * DIGITS;

  ir_entry_state_t state, state_next;

  logic [BCD_W-1:0] acc_bcd;
  logic [BIN_W-1:0] acc_bin;
  logic [3:0]       acc_cnt;
  logic [3:0]       cnt_inc;
  logic             err_q;
  logic             err_rise;
  logic             digit_ok;
  logic             accept;
  logic             commit;
  logic             abort;
  logic             drop;
  logic             expired;
  logic             full_next;

  assign err_rise  = err && !err_q;
  assign digit_ok  = numberPressed && (numberPressedData <= 4'(IR_DIGIT_MAX));
  assign cnt_inc   = acc_cnt + 4'd1;
  assign full_next = (cnt_inc == 4'(DIGITS));

  ir_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept || state != ENTRY),
    .enable (state == ENTRY),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = full_next ? PEND : ENTRY;
      end
      ENTRY: begin
        if (abort)        state_next = IDLE;
        else if (accept)  state_next = full_next ? PEND : ENTRY;
        else if (expired) state_next = PEND;
      end
      PEND: begin
        if (abort || commit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    commit      = 1'b0;
    abort       = 1'b0;
    drop        = 1'b0;
    entryActive = (state != IDLE);
    unique case (state)
      IDLE: begin
        accept = digit_ok && !err_rise;
        drop   = digit_ok && err_rise;
      end
      ENTRY: begin
        abort  = err_rise;
        accept = digit_ok && !err_rise;
        drop   = digit_ok && err_rise;
      end
      PEND: begin
        abort  = err_rise;
        commit = !err_rise && (!outValid || outReady);
        drop   = digit_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_bcd <= '0;
      acc_bin <= '0;
      acc_cnt <= '0;
      err_q   <= 1'b0;
      dropped <= 1'b0;
    end else begin
      err_q   <= err;
      dropped <= drop;
      if (abort || commit) begin
        acc_bcd <= '0;
        acc_bin <= '0;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_bcd <= (acc_bcd << 4) | BCD_W'(numberPressedData);
        acc_bin <= acc_bin * BIN_W'(10) + BIN_W'(numberPressedData);
        acc_cnt <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid <= 1'b0;
      outBcd   <= '0;
      outBin   <= '0;
      outCount <= '0;
    end else if (commit) begin
      outValid <= 1'b1;
      outBcd   <= acc_bcd;
      outBin   <= acc_bin;
      outCount <= acc_cnt;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ir_number_entry.sv
// Directed bench for ir_number_entry with a 100-cycle timeout.
module tb_ir_number_entry;

  logic        clk;
  logic        rst;
  logic        numberPressed;
  logic [3:0]  numberPressedData;
  logic        err;
  logic        outReady;
  logic        outValid;
  logic [15:0] outBcd;
  logic [13:0] outBin;
  logic [3:0]  outCount;
  logic        entryActive;
  logic        dropped;

  int unsigned passed = 0;
  int unsigned total  = 0;

  ir_number_entry #(
    .DIGITS(4),
    .BIN_W(14),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .numberPressed    (numberPressed),
    .numberPressedData(numberPressedData),
    .err              (err),
    .outReady         (outReady),
    .outValid         (outValid),
    .outBcd           (outBcd),
    .outBin           (outBin),
    .outCount         (outCount),
    .entryActive      (entryActive),
    .dropped          (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    numberPressed     = 1'b1;
    numberPressedData = d;
    tick();
    numberPressed     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int unsigned seen;
    int unsigned seen_at;
    logic [13:0] seen_bin;
    logic [3:0]  seen_cnt;
    int unsigned n;

    rst               = 1'b0;
    numberPressed     = 1'b0;
    numberPressedData = 4'd0;
    err               = 1'b0;
    outReady          = 1'b1;
    #12;
    chk("reset_valid", 32'(outValid), 32'd0);
    chk("reset_bcd", 32'(outBcd), 32'd0);
    chk("reset_bin", 32'(outBin), 32'd0);
    chk("reset_cnt", 32'(outCount), 32'd0);
    chk("reset_active", 32'(entryActive), 32'd0);
    chk("reset_dropped", 32'(dropped), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1,2,3,4 completes on digit count
    press(4'd1);
    chk("t1_active", 32'(entryActive), 32'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    chk("t1_pend_active", 32'(entryActive), 32'd1);
    chk("t1_valid_early", 32'(outValid), 32'd0);
    tick();
    chk("t1_valid", 32'(outValid), 32'd1);
    chk("t1_bcd", 32'(outBcd), 32'h1234);
    chk("t1_bin", 32'(outBin), 32'd1234);
    chk("t1_cnt", 32'(outCount), 32'd4);
    chk("t1_idle", 32'(entryActive), 32'd0);
    tick();
    chk("t1_consumed", 32'(outValid), 32'd0);

    // 4,2 then timeout
    press(4'd4);
    press(4'd2);
    for (int i = 0; i < 99; i++) tick();
    chk("t2_valid_early", 32'(outValid), 32'd0);
    chk("t2_pend_active", 32'(entryActive), 32'd1);
    tick();
    chk("t2_valid", 32'(outValid), 32'd1);
    chk("t2_bcd", 32'(outBcd), 32'h0042);
    chk("t2_bin", 32'(outBin), 32'd42);
    chk("t2_cnt", 32'(outCount), 32'd2);
    tick();

    // 9,9 aborted by err edge, then 5 with timeout
    press(4'd9);
    press(4'd9);
    err = 1'b1;
    tick();
    chk("t3_abort_idle", 32'(entryActive), 32'd0);
    err = 1'b0;
    tick();
    press(4'd5);
    seen = 0; seen_at = 0; seen_bin = '0; seen_cnt = '0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (outValid) begin
        if (seen == 0) begin
          seen_at  = i;
          seen_bin = outBin;
          seen_cnt = outCount;
        end
        seen++;
      end
    end
    chk("t3_outputs", seen, 32'd1);
    chk("t3_latency", seen_at, 32'd100);
    chk("t3_bin", 32'(seen_bin), 32'd5);
    chk("t3_cnt", 32'(seen_cnt), 32'd1);

    // Back-pressure: held slot, queued entry, dropped digit
    outReady = 1'b0;
    press(4'd1); press(4'd1); press(4'd1); press(4'd1);
    tick();
    chk("t4_valid1", 32'(outValid), 32'd1);
    chk("t4_bin1", 32'(outBin), 32'd1111);
    press(4'd2); press(4'd2); press(4'd2); press(4'd2);
    tick();
    chk("t4_held_bcd", 32'(outBcd), 32'h1111);
    chk("t4_pend_active", 32'(entryActive), 32'd1);
    press(4'd3);
    chk("t4_dropped", 32'(dropped), 32'd1);
    chk("t4_still_held", 32'(outBin), 32'd1111);
    tick();
    chk("t4_dropped_pulse", 32'(dropped), 32'd0);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("t4_valid2", 32'(outValid), 32'd1);
    chk("t4_bin2", 32'(outBin), 32'd2222);
    chk("t4_bcd2", 32'(outBcd), 32'h2222);
    chk("t4_idle", 32'(entryActive), 32'd0);
    tick();
    chk("t4_valid_hold", 32'(outValid), 32'd1);
    outReady = 1'b1;
    tick();
    chk("t4_drained", 32'(outValid), 32'd0);

    // Reset mid-entry with a full slot
    outReady = 1'b0;
    press(4'd7); press(4'd7); press(4'd7); press(4'd7);
    tick();
    chk("t5_pre_valid", 32'(outValid), 32'd1);
    press(4'd8);
    chk("t5_pre_active", 32'(entryActive), 32'd1);
    rst = 1'b0;
    #2;
    chk("t5_rst_valid", 32'(outValid), 32'd0);
    chk("t5_rst_bin", 32'(outBin), 32'd0);
    chk("t5_rst_bcd", 32'(outBcd), 32'd0);
    chk("t5_rst_cnt", 32'(outCount), 32'd0);
    chk("t5_rst_active", 32'(entryActive), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    outReady = 1'b1;
    press(4'd6); press(4'd0); press(4'd0); press(4'd0);
    tick();
    chk("t5_valid", 32'(outValid), 32'd1);
    chk("t5_bin", 32'(outBin), 32'd6000);
    chk("t5_bcd", 32'(outBcd), 32'h6000);
    tick();

    // Non-digit code ignored
    press(4'hB);
    chk("t6_no_entry", 32'(entryActive), 32'd0);
    chk("t6_no_drop", 32'(dropped), 32'd0);
    press(4'd3); press(4'd1); press(4'd4); press(4'd1);
    tick();
    chk("t6_bin", 32'(outBin), 32'd3141);
    chk("t6_bcd", 32'(outBcd), 32'h3141);
    tick();

    // Leading zero counts as a digit
    press(4'd0);
    press(4'd7);
    n = 0;
    while (!outValid && n < 150) begin
      tick();
      n++;
    end
    chk("t7_latency", n, 32'd100);
    chk("t7_cnt", 32'(outCount), 32'd2);
    chk("t7_bin", 32'(outBin), 32'd7);
    chk("t7_bcd", 32'(outBcd), 32'h0007);
    tick();

    // Digit coinciding with an err edge is dropped
    err = 1'b1;
    press(4'd5);
    chk("t8_dropped", 32'(dropped), 32'd1);
    chk("t8_idle", 32'(entryActive), 32'd0);
    err = 1'b0;
    tick();
    chk("t8_dropped_pulse", 32'(dropped), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ir_number_entry.md
# ir_number_entry

Sequences key events from the IR remote decoder into multi-digit decimal numbers for the CPU. It consumes the decoder's one-cycle `numberPressed` strobe with its 4-bit digit, and its `err` level. Digits accumulate into one entry, which commits on digit-count limit or inter-digit timeout. The committed value is delivered in both BCD and binary through a single-slot valid/ready output register read by the CPU-side I/O logic.

## Interface
- `DIGITS`, 4: maximum digits per entry (1..8).
- `BIN_W`, 14: binary result width; must satisfy 10^DIGITS−1 < 2^BIN_W.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles after the last digit before auto-commit (1 s at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-low; all state is cleared while low.
- `numberPressed`  in  1  one-cycle strobe from the IR decoder.
- `numberPressedData`  in  4  digit 0–9 qualified by `numberPressed`; values 10–15 are ignored (no state change).
- `err`  in  1  decoder error level.
- `outReady`  in  1  consumer accepts the output this cycle.
- `outValid`  out  1  output slot holds a committed number.
- `outBcd`  out  4*DIGITS  committed number in BCD, least-significant digit in [3:0], right-aligned.
- `outBin`  out  BIN_W  committed number in binary.
- `outCount`  out  4  digits in the committed number (1..DIGITS).
- `entryActive`  out  1  high in ENTRY and PEND.
- `dropped`  out  1  one-cycle pulse when a digit is discarded.

Reset values: every output is 0.

## Operation
- States: IDLE, ENTRY, PEND.
- Accepting a digit `d` updates the accumulator:
  - `bcd` ← `{bcd[4*DIGITS-5:0], d}`.
  - `bin` ← `bin*10 + d`, truncated to BIN_W.
  - `cnt` ← `cnt+1`.
  - The timer is cleared.
- IDLE:
  - A valid digit is accepted and the block enters ENTRY.
  - `err` edges are ignored.
- ENTRY:
  - Each valid digit is accepted.
  - When `cnt` reaches DIGITS, or the timer reaches TIMEOUT_CYCLES−1, the entry is complete and the block goes to PEND.
- PEND:
  - Commit happens when the slot is free, i.e. `!outValid || outReady`.
  - Commit loads `outBcd`, `outBin` and `outCount` and sets `outValid`.
  - After commit, the accumulator, `cnt` and timer clear and the block returns to IDLE.
  - A digit arriving in PEND is discarded and pulses `dropped`.
- Abort: a rising edge of `err` in ENTRY or PEND clears the accumulator, `cnt` and timer and returns to IDLE. `outValid` is not affected.
- Output slot:
  - `outValid` falls on `outValid && outReady` unless a commit occurs in the same cycle.
  - If a commit coincides with a handshake, the new value replaces the old and `outValid` stays high.
  - Data are stable while `outValid && !outReady`.
- Leading zeros count as digits: entering 0,7 gives `outCount`=2, `outBin`=7.

## Timing
- A digit strobe at cycle N is reflected in the accumulator and state at N+1.
- With the slot free, the last digit (N) reaches PEND at N+1 and gives `outValid` at N+2.
- Timeout commit: the last digit at cycle N gives PEND at N+TIMEOUT_CYCLES and `outValid` one cycle later (slot free).
- Simultaneous events, highest priority first:
  - `err` rising edge: abort.
  - Commit.
  - Digit accept.
- A digit strobe in the cycle of an `err` rising edge is discarded and pulses `dropped`.
- Digit-count completion takes priority over timeout in the same cycle; both commit identically.
- `err` edge detect uses a registered copy of `err`. This register clears to 0 on reset, so `err` already high at reset release counts as an edge.
- Reset asserted mid-entry: the entry is lost, and `outValid` and all outputs return to 0 immediately (asynchronously).

## Structure
- Shared package `ir_pkg`:
  - State enum `ir_entry_state_t` (IDLE, ENTRY, PEND).
  - `IR_DIGIT_MAX` = 9.
  - `ir_clk_hz` constant (50_000_000), shared with the IR decoder's tick constants.
- One natural sub-module: `ir_idle_timer`.
  - Width `$clog2(TIMEOUT_CYCLES)`.
  - Inputs: clear and enable.
  - Output: one-cycle `expired` when the count reaches TIMEOUT_CYCLES−1; the count saturates there.
- Everything else (accumulator, FSM, output slot) sits in `ir_number_entry`.

## Test plan
- All directed tests run with TIMEOUT_CYCLES=100 to keep timeouts short.
- Digits 1,2,3,4 with `outReady`=1 → `outValid` 2 cycles after the '4' strobe; `outBcd`=16'h1234, `outBin`=1234, `outCount`=4.
- Digits 4,2, then silence → `outValid` 101 cycles after the '2' strobe; `outBcd`=16'h0042, `outBin`=42, `outCount`=2.
- Digits 9,9 then an `err` rising edge, then 5 followed by timeout → only one output: `outBin`=5, `outCount`=1.
- `outReady`=0; entries 1,1,1,1 then 2,2,2,2, then a digit 3 → first value held at 1111; second entry waits in PEND; digit 3 pulses `dropped`. Raising `outReady` for one cycle gives 2222 with `outValid` continuously high.
- Digit 8 entered, then `rst` low for 1 cycle → all outputs 0, state IDLE; next digits 6,0,0,0 → `outBin`=6000.
- Strobe with `numberPressedData`=4'hB → no state change, no `dropped` pulse; a following entry 3,1,4,1 → 3141.
